// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read arbiter: FSM encoding, default sizes
// and the modulo helper used by the round-robin picker.
package fifo_rd_arbiter_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int CNT_W         = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // (idx + k) mod n for 0 <= idx < n and 1 <= k <= n; no power-of-2 assumption.
    function automatic int wrap_inc(input int idx, input int k, input int n);
        int s;
        s = idx + k;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of the FIFO-side read signals and the tagged valid/ready output stream.
interface fifo_rd_arbiter_if
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = 2
);

    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH*WIDTH-1:0] fifo_dq;
    logic [NUM_CH-1:0]       r_en;
    logic                    m_valid;
    logic                    m_ready;
    logic [WIDTH-1:0]        m_data;
    logic [CH_W-1:0]         m_ch;
    logic                    m_last;
    logic                    busy;

    modport master (
        input  ch_en, empty, fifo_dq, m_ready,
        output r_en, m_valid, m_data, m_ch, m_last, busy
    );

    modport slave (
        output ch_en, empty, fifo_dq, m_ready,
        input  r_en, m_valid, m_data, m_ch, m_last, busy
    );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_i, wrapping.
module fifo_rd_arbiter_rr_pick
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic              hit_o,
    output logic [CH_W-1:0]   idx_o
);

    logic [CH_W-1:0] cand;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        // k = NUM_CH revisits last_i itself, so a lone requester keeps winning.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'(wrap_inc(int'(last_i), k, NUM_CH));
            if (!hit_o && req_i[cand]) begin
                hit_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler draining NUM_CH FIFOs into one tagged valid/ready stream.
// state    | meaning
// ST_IDLE  | arbitration cycle, no reads issued
// ST_BURST | reading granted channel g_q until MAX_BURST words or empty
module fifo_rd_arbiter
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CH_W      = 2
) (
    input  logic           r_clk,
    input  logic           r_rst,
    fifo_rd_arbiter_if.master bus
);

    arb_state_e      state_q;
    logic [CH_W-1:0] g_q;
    logic [CH_W-1:0] last_q;
    cnt_t            cnt_q;
    logic            pend_q;
    logic [CH_W-1:0] pend_ch_q;
    logic            pend_last_q;
    logic            m_valid_q;
    logic [WIDTH-1:0] m_data_q;
    logic [CH_W-1:0] m_ch_q;
    logic            m_last_q;

    logic [NUM_CH-1:0] req;
    logic              pick_hit;
    logic [CH_W-1:0]   pick_idx;
    logic              capture;
    logic              issue;
    cnt_t              cnt_d;
    logic              burst_done;
    logic [NUM_CH-1:0] r_en_d;
    logic [WIDTH-1:0]  dq_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_dq
        assign dq_arr[i] = bus.fifo_dq[i*WIDTH +: WIDTH];
    end

    assign req = bus.ch_en & ~bus.empty;

    fifo_rd_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .hit_o  (pick_hit),
        .idx_o  (pick_idx)
    );

    // A new read may only go out when the pending word leaves this cycle,
    // so at most one word sits between the FIFO and the output register.
    assign capture    = pend_q && (!m_valid_q || bus.m_ready);
    assign issue      = (state_q == ST_BURST) && !bus.empty[g_q] && (!pend_q || capture);
    assign cnt_d      = cnt_q + cnt_t'(1);
    assign burst_done = (cnt_d == cnt_t'(MAX_BURST));

    always_comb begin
        r_en_d = '0;
        if (issue) r_en_d[g_q] = 1'b1;
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            pend_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_ch_q      <= '0;
            m_last_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_hit) begin
                        g_q     <= pick_idx;
                        last_q  <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (issue) begin
                        cnt_q <= cnt_d;
                        if (burst_done) state_q <= ST_IDLE;
                    end else if (bus.empty[g_q]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (issue) begin
                pend_q      <= 1'b1;
                pend_ch_q   <= g_q;
                pend_last_q <= burst_done;
            end else if (capture) begin
                pend_q <= 1'b0;
            end

            if (capture) begin
                m_valid_q <= 1'b1;
                m_data_q  <= dq_arr[pend_ch_q];
                m_ch_q    <= pend_ch_q;
                m_last_q  <= pend_last_q;
            end else if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.r_en    = r_en_d;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_ch    = m_ch_q;
    assign bus.m_last  = m_last_q;
    assign bus.busy    = (state_q != ST_IDLE) || pend_q || m_valid_q;

endmodule
